// File: rtl/farm_pkg.sv
// Shared types for the farm memory-port arbiter and its tag FIFO.
package farm_pkg;

  // Which requester owns an in-flight memory transaction.
  typedef enum logic {
    OWN_IF,
    OWN_D
  } mem_owner_e;

  // Per-transaction tag: owner plus "discard the response" flag.
  typedef struct packed {
    mem_owner_e owner;
    logic       kill;
  } arb_tag_t;

  // Arbiter FSM: IDLE picks a winner, HOLD keeps it until the memory grants.
  typedef enum logic {
    ARB_IDLE,
    ARB_HOLD
  } arb_state_e;

endpackage

// File: rtl/farm_arb_tagq.sv
// In-order tag FIFO for outstanding memory transactions, with a bulk kill
// that marks every queued fetch entry so its response is dropped.
module farm_arb_tagq
  import farm_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push_i,
  input  arb_tag_t push_tag_i,
  input  logic     pop_i,
  input  logic     kill_if_i,
  output arb_tag_t head_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  arb_tag_t            mem_q [Depth];
  arb_tag_t            mem_d [Depth];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push_i && (!full_o || do_pop);

  // Head as seen this cycle, including a kill arriving in the same cycle.
  always_comb begin
    head_o = mem_q[rd_ptr_q];
    if (kill_if_i && (mem_q[rd_ptr_q].owner == OWN_IF)) begin
      head_o.kill = 1'b1;
    end
  end

  // Next-state: kill-mark fetch entries, then write the new tag and move pointers.
  always_comb begin
    for (int unsigned i = 0; i < Depth; i++) begin
      mem_d[i] = mem_q[i];
      if (kill_if_i && (mem_q[i].owner == OWN_IF)) begin
        mem_d[i].kill = 1'b1;
      end
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_tag_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // FIFO state registers; reset drops every in-flight tag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '{owner: OWN_IF, kill: 1'b0};
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/farm_mem_arb.sv
// Arbitrates the single memory port between instruction fetch and data
// load/store, tracks owners of in-flight requests and routes responses back.
module farm_mem_arb
  import farm_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned MAX_OUTST  = 2,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            if_req_i,
  input  logic [AW-1:0]   if_addr_i,
  output logic            if_gnt_o,
  output logic            if_rvalid_o,
  output logic [DW-1:0]   if_rdata_o,
  input  logic            if_kill_i,
  input  logic            d_req_i,
  input  logic            d_we_i,
  input  logic [DW/8-1:0] d_be_i,
  input  logic [AW-1:0]   d_addr_i,
  input  logic [DW-1:0]   d_wdata_i,
  output logic            d_gnt_o,
  output logic            d_rvalid_o,
  output logic [DW-1:0]   d_rdata_o,
  output logic            m_req_o,
  output logic            m_we_o,
  output logic [DW/8-1:0] m_be_o,
  output logic [AW-1:0]   m_addr_o,
  output logic [DW-1:0]   m_wdata_o,
  input  logic            m_gnt_i,
  input  logic            m_rvalid_i,
  input  logic [DW-1:0]   m_rdata_i
);

  localparam int unsigned SW = $clog2(STARVE_LIM + 1);

  arb_state_e  state_q, state_d;
  mem_owner_e  owner_q, owner_d;
  logic [SW-1:0] starve_q, starve_d;

  mem_owner_e sel;
  logic       req;
  logic       gnt;
  logic       can_accept;
  arb_tag_t   push_tag;
  arb_tag_t   head;
  logic       tq_full, tq_empty;
  logic       pop;

  assign pop        = m_rvalid_i && !tq_empty;
  // A response popping this cycle frees a slot for a new grant.
  assign can_accept = !tq_full || pop;

  // Winner selection and FSM next-state.
  always_comb begin
    sel     = OWN_D;
    req     = 1'b0;
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      ARB_IDLE: begin
        if (can_accept) begin
          if (d_req_i && (!if_req_i || (starve_q < SW'(STARVE_LIM)))) begin
            sel = OWN_D;
            req = 1'b1;
          end else if (if_req_i) begin
            sel = OWN_IF;
            req = 1'b1;
          end
        end
        if (req && !m_gnt_i) begin
          state_d = ARB_HOLD;
          owner_d = sel;
        end
      end
      ARB_HOLD: begin
        sel = owner_q;
        req = 1'b1;
        if (m_gnt_i) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign gnt      = req && m_gnt_i;
  assign if_gnt_o = gnt && (sel == OWN_IF);
  assign d_gnt_o  = gnt && (sel == OWN_D);

  // A held fetch granted during a redirect is still accepted but its data dropped.
  assign push_tag = '{owner: sel,
                      kill:  (state_q == ARB_HOLD) && (sel == OWN_IF) && if_kill_i};

  // Memory request fields, zero whenever no request is presented.
  always_comb begin
    m_req_o   = req;
    m_we_o    = 1'b0;
    m_be_o    = '0;
    m_addr_o  = '0;
    m_wdata_o = '0;
    if (req) begin
      if (sel == OWN_D) begin
        m_we_o    = d_we_i;
        m_be_o    = d_be_i;
        m_addr_o  = d_addr_i;
        m_wdata_o = d_wdata_i;
      end else begin
        m_be_o   = '1;
        m_addr_o = if_addr_i;
      end
    end
  end

  // Starvation counter: consecutive data grants while fetch is waiting.
  always_comb begin
    starve_d = starve_q;
    if (if_gnt_o || !if_req_i) begin
      starve_d = '0;
    end else if (d_gnt_o && (starve_q != SW'(STARVE_LIM))) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Response routing, combinational from m_rvalid.
  always_comb begin
    if_rvalid_o = pop && (head.owner == OWN_IF) && !head.kill;
    d_rvalid_o  = pop && (head.owner == OWN_D);
    if_rdata_o  = if_rvalid_o ? m_rdata_i : '0;
    d_rdata_o   = d_rvalid_o ? m_rdata_i : '0;
  end

  farm_arb_tagq #(
    .Depth(MAX_OUTST)
  ) u_tagq (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (gnt),
    .push_tag_i (push_tag),
    .pop_i      (m_rvalid_i),
    .kill_if_i  (if_kill_i),
    .head_o     (head),
    .full_o     (tq_full),
    .empty_o    (tq_empty)
  );

  // Arbiter state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ARB_IDLE;
      owner_q  <= OWN_IF;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

`ifdef FARM_ARB_STRICT
  // Response with nothing outstanding is a memory protocol violation.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(m_rvalid_i && tq_empty))
        else $error("farm_mem_arb: m_rvalid with empty tag FIFO");
    end
  end
`endif

endmodule

// File: tb/tb_farm_mem_arb.sv
module tb_farm_mem_arb;

  logic        clk, rst_n;
  logic        if_req, if_gnt, if_rvalid, if_kill;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        m_req, m_we, m_gnt, m_rvalid;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata, m_rdata;

  typedef struct {
    logic own_d;
    logic kill;
  } exp_t;

  exp_t sbq[$];
  int   ntests = 0;
  int   nfail  = 0;
  bit   t2_is_if [7] = '{0, 0, 0, 0, 1, 0, 0};

  farm_mem_arb #(
    .AW(32), .DW(32), .MAX_OUTST(2), .STARVE_LIM(4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .if_gnt_o    (if_gnt),
    .if_rvalid_o (if_rvalid),
    .if_rdata_o  (if_rdata),
    .if_kill_i   (if_kill),
    .d_req_i     (d_req),
    .d_we_i      (d_we),
    .d_be_i      (d_be),
    .d_addr_i    (d_addr),
    .d_wdata_i   (d_wdata),
    .d_gnt_o     (d_gnt),
    .d_rvalid_o  (d_rvalid),
    .d_rdata_o   (d_rdata),
    .m_req_o     (m_req),
    .m_we_o      (m_we),
    .m_be_o      (m_be),
    .m_addr_o    (m_addr),
    .m_wdata_o   (m_wdata),
    .m_gnt_i     (m_gnt),
    .m_rvalid_i  (m_rvalid),
    .m_rdata_i   (m_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t mk(input logic own_d, input logic kill);
    exp_t e;
    e.own_d = own_d;
    e.kill  = kill;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    if_req = 0; if_addr = '0; if_kill = 0;
    d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
    m_gnt = 0; m_rvalid = 0; m_rdata = '0;
  endtask

  // Advance to the next falling edge and return all inputs to idle.
  task automatic step();
    @(negedge clk);
    clear_inputs();
  endtask

  // A redirect marks every queued fetch expectation as dropped.
  task automatic mark_kill();
    foreach (sbq[i]) if (!sbq[i].own_d) sbq[i].kill = 1'b1;
  endtask

  task automatic gnt_check(input string tag, input logic e_if, input logic e_d);
    chk({tag, ".if_gnt"}, if_gnt, e_if);
    chk({tag, ".d_gnt"}, d_gnt, e_d);
  endtask

  // Pop the scoreboard on each memory response and compare the routing.
  task automatic resp_check(input string tag);
    exp_t e;
    logic e_if, e_d;
    e_if = 0;
    e_d  = 0;
    if (m_rvalid && sbq.size() > 0) begin
      e    = sbq.pop_front();
      e_d  = e.own_d;
      e_if = !e.own_d && !e.kill;
    end
    chk({tag, ".if_rvalid"}, if_rvalid, e_if);
    chk({tag, ".d_rvalid"}, d_rvalid, e_d);
    chk({tag, ".if_rdata"}, if_rdata, e_if ? m_rdata : 32'h0);
    chk({tag, ".d_rdata"}, d_rdata, e_d ? m_rdata : 32'h0);
  endtask

  task automatic out_zero(input string tag);
    chk({tag, ".if_gnt"}, if_gnt, 0);
    chk({tag, ".if_rvalid"}, if_rvalid, 0);
    chk({tag, ".if_rdata"}, if_rdata, 0);
    chk({tag, ".d_gnt"}, d_gnt, 0);
    chk({tag, ".d_rvalid"}, d_rvalid, 0);
    chk({tag, ".d_rdata"}, d_rdata, 0);
    chk({tag, ".m_req"}, m_req, 0);
    chk({tag, ".m_we"}, m_we, 0);
    chk({tag, ".m_be"}, m_be, 0);
    chk({tag, ".m_addr"}, m_addr, 0);
    chk({tag, ".m_wdata"}, m_wdata, 0);
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    repeat (2) @(negedge clk);
    #1 out_zero("reset");
    @(negedge clk);
    rst_n = 1;

    // 1: single fetch, response one cycle later
    step(); if_req = 1; if_addr = 32'h10; m_gnt = 1;
    #1 gnt_check("t1", 1, 0);
    chk("t1.m_addr", m_addr, 32'h10);
    chk("t1.m_we", m_we, 0);
    sbq.push_back(mk(0, 0));
    step(); m_rvalid = 1; m_rdata = 32'h00500093;
    #1 resp_check("t1r");
    chk("t1.m_req_idle", m_req, 0);

    // 2: both requesting, starvation forces a fetch grant on the fifth cycle
    for (int k = 0; k < 7; k++) begin
      step(); if_req = 1; d_req = 1; if_addr = 32'h40; d_addr = 32'h100 + k; m_gnt = 1;
      if (k > 0) begin
        m_rvalid = 1;
        m_rdata  = 32'hA000 + k;
      end
      #1 resp_check("t2r");
      gnt_check("t2", t2_is_if[k], !t2_is_if[k]);
      chk("t2.m_addr", m_addr, t2_is_if[k] ? 32'h40 : 32'h100 + k);
      sbq.push_back(mk(!t2_is_if[k], 0));
    end
    step(); m_rvalid = 1; m_rdata = 32'hA007;
    #1 resp_check("t2drain");

    // 3: data request held for three cycles without a memory grant
    for (int k = 0; k < 4; k++) begin
      step(); d_req = 1; d_addr = 32'h300; if_req = (k >= 1); if_addr = 32'h44;
      m_gnt = (k == 3);
      #1 chk("t3.m_req", m_req, 1);
      chk("t3.m_addr", m_addr, 32'h300);
      gnt_check("t3", 0, k == 3);
      if (k == 3) sbq.push_back(mk(1, 0));
    end
    step(); m_rvalid = 1; m_rdata = 32'h1234;
    #1 resp_check("t3r");

    // 4: FIFO full of fetches, kill, refusal, then a held fetch killed at grant
    step(); if_req = 1; if_addr = 32'h20; m_gnt = 1;
    #1 gnt_check("t4a", 1, 0);
    sbq.push_back(mk(0, 0));
    step(); if_req = 1; if_addr = 32'h24; m_gnt = 1;
    #1 gnt_check("t4b", 1, 0);
    sbq.push_back(mk(0, 0));
    step(); if_req = 1; if_addr = 32'h28; m_gnt = 1; if_kill = 1;
    mark_kill();
    #1 chk("t4full.m_req", m_req, 0);
    gnt_check("t4full", 0, 0);
    resp_check("t4full");
    step(); if_req = 1; if_addr = 32'h28; m_gnt = 1;
    #1 chk("t4full2.m_req", m_req, 0);
    gnt_check("t4full2", 0, 0);
    step(); if_req = 1; if_addr = 32'h28; m_rvalid = 1; m_rdata = 32'h5555;
    #1 resp_check("t4pop1");
    chk("t4pop1.m_req", m_req, 1);
    chk("t4pop1.m_addr", m_addr, 32'h28);
    gnt_check("t4pop1", 0, 0);
    step(); if_req = 1; if_addr = 32'h28; m_gnt = 1; if_kill = 1;
    m_rvalid = 1; m_rdata = 32'h6666;
    mark_kill();
    #1 resp_check("t4pop2");
    gnt_check("t4hold", 1, 0);
    sbq.push_back(mk(0, 1));
    step(); m_rvalid = 1; m_rdata = 32'h7777;
    #1 resp_check("t4pop3");

    // 5: store pass-through and acknowledge
    step(); d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
    m_gnt = 1;
    #1 gnt_check("t5", 0, 1);
    chk("t5.m_we", m_we, 1);
    chk("t5.m_be", m_be, 4'b0011);
    chk("t5.m_addr", m_addr, 32'h200);
    chk("t5.m_wdata", m_wdata, 32'hDEADBEEF);
    sbq.push_back(mk(1, 0));
    step(); m_rvalid = 1; m_rdata = 32'h0;
    #1 resp_check("t5ack");

    // 6: reset with two transactions in flight
    step(); if_req = 1; if_addr = 32'h30; m_gnt = 1;
    #1 gnt_check("t6a", 1, 0);
    step(); d_req = 1; d_addr = 32'h400; m_gnt = 1;
    #1 gnt_check("t6b", 0, 1);
    step(); rst_n = 0;
    sbq.delete();
    #1 out_zero("t6rst");
    step(); rst_n = 1;
    step(); m_rvalid = 1; m_rdata = 32'hBAD;
    #1 resp_check("t6stray");
    step(); if_req = 1; if_addr = 32'h34; m_gnt = 1;
    #1 gnt_check("t6c", 1, 0);
    chk("t6c.m_addr", m_addr, 32'h34);
    sbq.push_back(mk(0, 0));
    step(); m_rvalid = 1; m_rdata = 32'h0FEDCBA9;
    #1 resp_check("t6r");
    chk("sb.empty", sbq.size(), 0);

    step();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/farm_mem_arb.md
Name: farm_mem_arb

Overview:
- Arbitrates the single program/data memory port in farm_pmi between instruction fetch (farm_fetch) and data load/store (farm_dec/execute).
- Up to MAX_OUTST accepted transactions may be in flight. Responses return in order and are routed back to their owner.
- Owner tags are held in a small FIFO.

Parameters:
- AW, 32: address width.
- DW, 32: data width.
- MAX_OUTST, 2: max accepted-but-unanswered transactions (power of 2, >=1).
- STARVE_LIM, 4: consecutive data grants, while fetch waits, that force one fetch grant.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request
- if_addr  in  AW  fetch word address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DW  fetch read data
- if_kill  in  1  discard all outstanding fetch responses (branch/jump redirect)
- d_req  in  1  data request
- d_we  in  1  1=store, 0=load
- d_be  in  DW/8  byte enables
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_gnt  out  1  data request accepted
- d_rvalid  out  1  load data / store ack valid
- d_rdata  out  DW  load data
- m_req  out  1  memory request
- m_we  out  1  memory write
- m_be  out  DW/8  memory byte enables
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_gnt  in  1  memory accepts request this cycle
- m_rvalid  in  1  memory response (one per accepted request, stores included)
- m_rdata  in  DW  memory read data

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0.
  - FSM=IDLE, tag FIFO empty, starve counter 0.
  - Reset mid-transaction drops all in-flight tags. Responses arriving after reset are ignored (FIFO empty).
- FSM IDLE:
  - Selection requires tag FIFO not full; otherwise m_req=0.
  - If d_req and (!if_req or starve<STARVE_LIM), select D.
  - Else if if_req, select IF.
  - m_req and the m_* fields are driven combinationally from the selected requester in the same cycle.
  - If m_gnt: x_gnt=1 for the winner only, push tag {owner, kill=0}, stay IDLE.
  - If !m_gnt: latch the owner and go to HOLD.
- FSM HOLD:
  - Owner locked. m_req=1, fields from the locked requester. Requesters must keep their request stable until gnt.
  - On m_gnt: grant, push tag, return to IDLE.
  - An IF owner in HOLD is still granted even if if_kill asserts; its tag is pushed with kill=1.
- Starve counter:
  - Increments on a D grant while if_req=1. Saturates at STARVE_LIM.
  - Clears on any IF grant or when if_req=0.
- Response path:
  - On m_rvalid, pop the FIFO head.
  - owner=IF, kill=0: if_rvalid=1, if_rdata=m_rdata.
  - owner=IF, kill=1: dropped, no rvalid.
  - owner=D: d_rvalid=1, d_rdata=m_rdata.
  - rvalid outputs are combinational from m_rvalid (zero-cycle). Rdata is 0 when its rvalid is low.
- if_kill: sets kill on every FIFO entry with owner=IF in the same cycle. An entry popped that cycle is dropped.
- Simultaneous push and pop: allowed when full (pop frees a slot first). Count is unchanged.
- m_rvalid with FIFO empty: protocol error. Ignored; a simulation-only assertion fires.
- Max throughput: 1 grant/cycle, MAX_OUTST outstanding.

Decomposition:
- farm_pkg additions:
  - typedef enum logic {OWN_IF, OWN_D} mem_owner_e
  - typedef struct packed {mem_owner_e owner; logic kill;} arb_tag_t
  - typedef enum logic {ARB_IDLE, ARB_HOLD} arb_state_e
- Sub-module farm_arb_tagq: MAX_OUTST-deep tag FIFO with push, pop, full, empty, and a bulk kill-mark port for IF entries.

Test Plan:
1. Fetch only: if_req=1, if_addr=0x10, m_gnt=1, m_rvalid one cycle later with 0x00500093 -> if_gnt=1 at cycle 0; if_rvalid=1, if_rdata=0x00500093 at cycle 1; d_rvalid stays 0.
2. Both requesting, m_gnt=1 every cycle, memory latency 1 -> four D grants, then one IF grant on the fifth cycle (STARVE_LIM=4), then D again; responses routed D,D,D,D,IF in order.
3. m_gnt=0 for 3 cycles with D selected, if_req rising in cycle 1 -> FSM stays in HOLD, m_addr=d_addr stable, owner stays D; d_gnt only when m_gnt=1.
4. Two fetches outstanding (FIFO full), if_kill pulsed, then two m_rvalid -> if_rvalid never asserts. A third request is refused (m_req=0) until the first pop.
5. Store: d_we=1, d_be=4'b0011, d_addr=0x200, d_wdata=0xDEADBEEF -> m_we=1, m_be=0011, m_wdata passed through; the ack gives d_rvalid=1.
6. rst_n=0 with 2 transactions outstanding, then released -> all outputs 0, FIFO empty; a stray m_rvalid produces no rvalid; the next fetch is granted normally.
